regfile_xfer_ctrl: RTL and testbench
====================================

# regfile_xfer_ctrl

Sequencer for the 4x8 register file on the shared 8-bit databus. It accepts one transfer command at a time over a valid/ready handshake and drives the register file's load/enable/select lines plus its own tri-state bus driver. Supported commands: register move, load-immediate, register swap and register read-out. It sits between the instruction decoder and the register file, and is the only block allowed to drive the register-file control pins.

## Interface
Parameters:
- DATA_W, 8, databus width
- SEL_W, 2, register select width (4 registers)

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command (IDLE only)
- cmd_op  in  2  00 MOV (rd<=rs), 01 LDI (rd<=imm), 10 SWAP (rd<->rs), 11 RD (rd_data<=rs)
- cmd_rd  in  SEL_W  destination register
- cmd_rs  in  SEL_W  source register
- cmd_imm  in  DATA_W  immediate for LDI
- rf_load  out  1  register file load strobe
- rf_enable  out  1  register file bus-output enable
- rf_in_sel  out  SEL_W  register file write select
- rf_out_sel  out  SEL_W  register file read select
- bus_in  in  DATA_W  resolved databus value
- bus_out  out  DATA_W  value this block drives on the databus
- bus_oe  out  1  this block drives the databus
- rd_data  out  DATA_W  result of last RD
- rd_valid  out  1  one-cycle pulse, rd_data updated
- done  out  1  one-cycle pulse in a command's final execute cycle

## Operation
- State machine states: IDLE, EXEC, SWP1, SWP2, SWP3.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready at a rising edge, latch op/rd/rs/imm. MOV, LDI and RD go to EXEC. SWAP goes to SWP1 when rd!=rs and to EXEC when rd==rs.
- Latched fields are used for the whole command. Input changes after acceptance are ignored.
- EXEC cycle actions by op:
  - MOV: rf_enable=1, rf_out_sel=rs, rf_load=1, rf_in_sel=rd.
  - LDI: bus_oe=1, bus_out=imm, rf_load=1, rf_in_sel=rd.
  - RD: rf_enable=1, rf_out_sel=rs; rd_data<=bus_in at the edge ending the cycle.
  - SWAP with rd==rs: no-op; all strobes stay 0.
- SWAP sequence:
  - SWP1: rf_enable=1, rf_out_sel=rs; temp<=bus_in.
  - SWP2: rf_enable=1, rf_out_sel=rd, rf_load=1, rf_in_sel=rs.
  - SWP3: bus_oe=1, bus_out=temp, rf_load=1, rf_in_sel=rd.
- done=1 in EXEC and in SWP3. The next state after either is IDLE.
- Invariant: rf_enable and bus_oe are never 1 in the same cycle.
- Outputs outside active cycles: rf_load, rf_enable and bus_oe are 0; bus_out and the selects are 0.
- MOV with rd==rs executes normally; it is a harmless self-load.

## Timing
- Command accepted at edge N. Execute cycles are N..N+1 for MOV/LDI/RD and N..N+3 for SWAP. The controller is back in IDLE after the last execute edge.
- Throughput: one MOV/LDI/RD per 2 cycles; one SWAP per 4 cycles.
- rf_load is sampled by the register file at the edge ending the cycle in which it is asserted.
- rd_data and rd_valid are registered. rd_valid=1 for exactly the one cycle after RD's EXEC, concurrent with IDLE. rd_data holds its value until the next RD.
- Outputs decode combinationally from state plus the latched command. There is no path from cmd_* to rf_*/bus_* in the same cycle.
- Reset (reset_n=0 at an edge) forces the following on the next cycle:
  - state=IDLE, cmd_ready=1;
  - rf_load=0, rf_enable=0, bus_oe=0, bus_out=0, selects=0;
  - temp=0, rd_data=0, rd_valid=0, done=0.
- Reset mid-SWAP aborts immediately with no further loads. A partially written register file (rs already overwritten) is accepted.
- cmd_valid held while busy: cmd_ready=0 and the command waits. It is accepted at the first IDLE edge.

## Test plan
- LDI rd=2, imm=0xA5 -> one cycle with bus_oe=1, bus_out=0xA5, rf_load=1, rf_in_sel=2, done=1; then a RD of r2 gives rd_data=0xA5 with a rd_valid pulse.
- r0=0x11, MOV rd=3 rs=0 -> rf_enable=1, rf_out_sel=0, rf_load=1, rf_in_sel=3 in one cycle; a later RD of r3 returns 0x11.
- r1=0x3C, r2=0xC3, SWAP rd=1 rs=2 -> SWP1/SWP2/SWP3 strobes as specified, done only in SWP3, cmd_ready=0 for 3 cycles; r1=0xC3, r2=0x3C; bus_oe and rf_enable never both 1.
- SWAP rd=rs=1 -> single EXEC cycle with done=1, no rf_load/rf_enable/bus_oe, r1 unchanged.
- Back-to-back: cmd_valid held high with LDI then MOV presented during LDI's EXEC -> MOV is accepted only at the IDLE edge, and its fields are latched at that edge, not earlier.
- Reset asserted during SWP2 -> next cycle: all strobes 0, cmd_ready=1, rd_data=0, done=0; no SWP3 load occurs.

Source files
------------

// File: rtl/regfile_xfer_ctrl.sv
// Transfer sequencer for a 4-entry register file on a shared databus.
// It runs one MOV/LDI/SWAP/RD command at a time and drives the register-file strobes and its own bus driver.
module regfile_xfer_ctrl #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [SEL_W-1:0]  cmd_rd,
  input  logic [SEL_W-1:0]  cmd_rs,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rf_load,
  output logic              rf_enable,
  output logic [SEL_W-1:0]  rf_in_sel,
  output logic [SEL_W-1:0]  rf_out_sel,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] EXEC = 3'd1;
  localparam logic [2:0] SWP1 = 3'd2;
  localparam logic [2:0] SWP2 = 3'd3;
  localparam logic [2:0] SWP3 = 3'd4;

  localparam logic [1:0] OP_MOV  = 2'd0;
  localparam logic [1:0] OP_LDI  = 2'd1;
  localparam logic [1:0] OP_SWAP = 2'd2;
  localparam logic [1:0] OP_RD   = 2'd3;

  logic [2:0]        state_reg, state_next;
  logic [1:0]        op_reg;
  logic [SEL_W-1:0]  rd_reg, rs_reg;
  logic [DATA_W-1:0] imm_reg, temp_reg, rd_data_reg;
  logic              rd_valid_reg;
  logic              accept;
  logic              rd_capture;

  assign accept     = cmd_valid && (state_reg == IDLE);
  assign rd_capture = (state_reg == EXEC) && (op_reg == OP_RD);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          // A swap of a register with itself collapses to a single no-op cycle.
          if (cmd_op == OP_SWAP && cmd_rd != cmd_rs) state_next = SWP1;
          else                                       state_next = EXEC;
        end
      end
      SWP1:    state_next = SWP2;
      SWP2:    state_next = SWP3;
      EXEC:    state_next = IDLE;
      SWP3:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      rd_reg       <= '0;
      rs_reg       <= '0;
      imm_reg      <= '0;
      temp_reg     <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_valid_reg <= rd_capture;
      if (accept) begin
        op_reg  <= cmd_op;
        rd_reg  <= cmd_rd;
        rs_reg  <= cmd_rs;
        imm_reg <= cmd_imm;
      end
      if (state_reg == SWP1) temp_reg <= bus_in;
      if (rd_capture)        rd_data_reg <= bus_in;
    end
  end

  // Outputs depend only on registered state, never on the live cmd_* inputs.
  always_comb begin
    cmd_ready  = (state_reg == IDLE);
    rf_load    = 1'b0;
    rf_enable  = 1'b0;
    rf_in_sel  = '0;
    rf_out_sel = '0;
    bus_oe     = 1'b0;
    bus_out    = '0;
    done       = 1'b0;
    case (state_reg)
      EXEC: begin
        done = 1'b1;
        case (op_reg)
          OP_MOV: begin
            rf_enable  = 1'b1;
            rf_out_sel = rs_reg;
            rf_load    = 1'b1;
            rf_in_sel  = rd_reg;
          end
          OP_LDI: begin
            bus_oe    = 1'b1;
            bus_out   = imm_reg;
            rf_load   = 1'b1;
            rf_in_sel = rd_reg;
          end
          OP_RD: begin
            rf_enable  = 1'b1;
            rf_out_sel = rs_reg;
          end
          default: ;
        endcase
      end
      SWP1: begin
        rf_enable  = 1'b1;
        rf_out_sel = rs_reg;
      end
      SWP2: begin
        rf_enable  = 1'b1;
        rf_out_sel = rd_reg;
        rf_load    = 1'b1;
        rf_in_sel  = rs_reg;
      end
      SWP3: begin
        bus_oe    = 1'b1;
        bus_out   = temp_reg;
        rf_load   = 1'b1;
        rf_in_sel = rd_reg;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_regfile_xfer_ctrl.sv
// Bench for regfile_xfer_ctrl: a behavioural register file answers the bus, and an
// array model of register contents supplies the expected strobes and results.
module tb_regfile_xfer_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_rd;
  logic [1:0] cmd_rs;
  logic [7:0] cmd_imm;
  logic       rf_load;
  logic       rf_enable;
  logic [1:0] rf_in_sel;
  logic [1:0] rf_out_sel;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;

  int total = 0;
  int bad   = 0;

  logic [7:0] rf [4];
  logic [7:0] model [4];
  logic       rf_clr;

  always #5 clock = ~clock;

  regfile_xfer_ctrl #(.DATA_W(8), .SEL_W(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .rf_load(rf_load), .rf_enable(rf_enable), .rf_in_sel(rf_in_sel), .rf_out_sel(rf_out_sel),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done)
  );

  // Register file and bus resolution seen by the controller.
  assign bus_in = bus_oe ? bus_out : (rf_enable ? rf[rf_out_sel] : 8'h00);

  always @(posedge clock) begin
    if (rf_clr) begin
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
    end else if (rf_load) begin
      rf[rf_in_sel] <= bus_in;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one command (DUT must be idle, called at a falling edge) and checks every cycle.
  // With hold set, cmd_valid stays high after acceptance carrying decoy fields.
  task automatic do_cmd(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [7:0] imm, input bit hold);
    int n;
    logic [7:0] v_rd, v_rs;
    logic e_load, e_en, e_oe, e_done;
    logic [7:0] e_bout;
    logic [1:0] e_in, e_out;
    logic [16:0] got, exp;
    bit rf_bad;
    v_rd = model[rd];
    v_rs = model[rs];
    n = (op == 2'd2 && rd != rs) ? 3 : 1;

    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready op=%0d got=%b exp=1", op, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
    @(posedge clock); #1;
    if (hold) begin
      cmd_op = 2'd0; cmd_rd = ~rd; cmd_rs = ~rs; cmd_imm = ~imm;
    end else begin
      cmd_valid = 1'b0;
      cmd_op  = 2'($urandom_range(0, 3));
      cmd_rd  = 2'($urandom_range(0, 3));
      cmd_rs  = 2'($urandom_range(0, 3));
      cmd_imm = 8'($urandom_range(0, 255));
    end

    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      e_load = 0; e_en = 0; e_oe = 0; e_bout = 0; e_in = 0; e_out = 0;
      e_done = (c == n - 1);
      case (op)
        2'd0: begin e_en = 1; e_out = rs; e_load = 1; e_in = rd; end
        2'd1: begin e_oe = 1; e_bout = imm; e_load = 1; e_in = rd; end
        2'd3: begin e_en = 1; e_out = rs; end
        default: begin
          if (n == 3) begin
            if (c == 0) begin e_en = 1; e_out = rs; end
            else if (c == 1) begin e_en = 1; e_out = rd; e_load = 1; e_in = rs; end
            else begin e_oe = 1; e_bout = v_rs; e_load = 1; e_in = rd; end
          end
        end
      endcase
      got = {rf_load, rf_enable, bus_oe, bus_out, rf_in_sel, rf_out_sel, done, cmd_ready};
      exp = {e_load, e_en, e_oe, e_bout, e_in, e_out, e_done, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL exec_strobes op=%0d rd=%0d rs=%0d cyc=%0d got=%h exp=%h", op, rd, rs, c, got, exp);
      end
      total++;
      if (rf_enable === 1'b1 && bus_oe === 1'b1) begin
        bad++;
        $display("FAIL bus_conflict op=%0d cyc=%0d got=both_on exp=exclusive", op, c);
      end
    end

    @(negedge clock);
    total++;
    if ({cmd_ready, done, rd_valid} !== {1'b1, 1'b0, (op == 2'd3)}) begin
      bad++;
      $display("FAIL post_cmd op=%0d got=%b exp=%b", op, {cmd_ready, done, rd_valid}, {1'b1, 1'b0, (op == 2'd3)});
    end
    if (op == 2'd3) begin
      total++;
      if (rd_data !== v_rs) begin
        bad++;
        $display("FAIL rd_data rs=%0d got=%h exp=%h", rs, rd_data, v_rs);
      end
    end

    case (op)
      2'd0: model[rd] = v_rs;
      2'd1: model[rd] = imm;
      2'd2: begin model[rd] = v_rs; model[rs] = v_rd; end
      default: ;
    endcase
    rf_bad = 0;
    for (int i = 0; i < 4; i++) if (rf[i] !== model[i]) rf_bad = 1;
    total++;
    if (rf_bad) begin
      bad++;
      $display("FAIL regfile op=%0d got=%h_%h_%h_%h exp=%h_%h_%h_%h", op,
               rf[3], rf[2], rf[1], rf[0], model[3], model[2], model[1], model[0]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rf_clr = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_rd = 2'd0; cmd_rs = 2'd0; cmd_imm = 8'h00;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++;
    if ({cmd_ready, rf_load, rf_enable, bus_oe, bus_out, rf_in_sel, rf_out_sel, rd_data, rd_valid, done}
        !== {1'b1, 3'b000, 8'h00, 4'h0, 8'h00, 2'b00}) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h",
               {cmd_ready, rf_load, rf_enable, bus_oe, bus_out, rf_in_sel, rf_out_sel, rd_data, rd_valid, done},
               {1'b1, 3'b000, 8'h00, 4'h0, 8'h00, 2'b00});
    end
    reset_n = 1'b1; rf_clr = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_ldi_rd();
    do_cmd(2'd1, 2'd2, 2'd0, 8'hA5, 0);
    do_cmd(2'd3, 2'd0, 2'd2, 8'h00, 0);
  endtask

  task automatic test_mov();
    do_cmd(2'd1, 2'd0, 2'd0, 8'h11, 0);
    do_cmd(2'd0, 2'd3, 2'd0, 8'h00, 0);
    do_cmd(2'd3, 2'd1, 2'd3, 8'h00, 0);
    do_cmd(2'd0, 2'd2, 2'd2, 8'h00, 0);
  endtask

  task automatic test_swap();
    do_cmd(2'd1, 2'd1, 2'd0, 8'h3C, 0);
    do_cmd(2'd1, 2'd2, 2'd0, 8'hC3, 0);
    do_cmd(2'd2, 2'd1, 2'd2, 8'h00, 0);
    do_cmd(2'd3, 2'd0, 2'd1, 8'h00, 0);
    do_cmd(2'd3, 2'd0, 2'd2, 8'h00, 0);
  endtask

  task automatic test_swap_same();
    do_cmd(2'd2, 2'd1, 2'd1, 8'h00, 0);
    do_cmd(2'd3, 2'd0, 2'd1, 8'h00, 0);
  endtask

  // Decoy MOV fields are held during LDI's execute cycle; the real MOV arrives in IDLE.
  task automatic test_back_to_back();
    do_cmd(2'd1, 2'd0, 2'd0, 8'h5E, 1);
    do_cmd(2'd0, 2'd1, 2'd0, 8'h00, 0);
    do_cmd(2'd3, 2'd2, 2'd1, 8'h00, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      do_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_mid_swap();
    bit rf_bad;
    do_cmd(2'd1, 2'd1, 2'd0, 8'h5A, 0);
    do_cmd(2'd1, 2'd2, 2'd0, 8'h77, 0);
    do_cmd(2'd3, 2'd0, 2'd1, 8'h00, 0);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_rd = 2'd1; cmd_rs = 2'd2; cmd_imm = 8'h00;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    total++;
    if ({rf_load, rf_in_sel, rf_out_sel} !== {1'b1, 2'd2, 2'd1}) begin
      bad++;
      $display("FAIL swp2_strobes got=%b exp=%b", {rf_load, rf_in_sel, rf_out_sel}, {1'b1, 2'd2, 2'd1});
    end
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    total++;
    if ({cmd_ready, rf_load, rf_enable, bus_oe, bus_out, rd_data, rd_valid, done}
        !== {1'b1, 3'b000, 8'h00, 8'h00, 2'b00}) begin
      bad++;
      $display("FAIL reset_mid_swap got=%h exp=%h",
               {cmd_ready, rf_load, rf_enable, bus_oe, bus_out, rd_data, rd_valid, done},
               {1'b1, 3'b000, 8'h00, 8'h00, 2'b00});
    end
    // The SWP2 write to rs has landed; the SWP3 write to rd must never happen.
    model[2] = model[1];
    @(negedge clock);
    rf_bad = 0;
    for (int i = 0; i < 4; i++) if (rf[i] !== model[i]) rf_bad = 1;
    total++;
    if (rf_bad || rf_load !== 1'b0) begin
      bad++;
      $display("FAIL no_swp3_load got=%h_%h_%h_%h load=%b exp=%h_%h_%h_%h load=0",
               rf[3], rf[2], rf[1], rf[0], rf_load, model[3], model[2], model[1], model[0]);
    end
  endtask

  initial begin
    test_reset();
    test_ldi_rd();
    test_mov();
    test_swap();
    test_swap_same();
    test_back_to_back();
    test_random();
    test_reset_mid_swap();
    test_ldi_rd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
